// File: rtl/frv_leak_pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frv_leak_pool_pkg
//  Purpose  : Shared definitions for the leakage-barrier random pool: FSM
//             state encoding, default LFSR constants and the LFSR step
//             function.
//  Revision : 1.0 - initial release
// ============================================================================
package frv_leak_pool_pkg;

    // Pool refill controller states.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2
    } leak_state_t;

    localparam logic [31:0] LEAK_DEF_TAPS  = 32'h80200003;
    localparam logic [31:0] LEAK_DEF_RESET = 32'hABCDEF37;

    // Widest LFSR the step function supports; narrower LFSRs are passed in
    // zero-extended and the caller keeps the low bits of the result.
    localparam int LEAK_MAX_W = 64;

    // Fibonacci XNOR LFSR step: shift left, feed back the XNOR-reduction of
    // the tapped bits into bit 0. Zero-extended upper bits are never tapped,
    // so they do not disturb the feedback.
    function automatic logic [LEAK_MAX_W-1:0] lfsr_next(
        input logic [LEAK_MAX_W-1:0] state,
        input logic [LEAK_MAX_W-1:0] taps
    );
        logic fb;
        fb = ~^(state & taps);
        return {state[LEAK_MAX_W-2:0], fb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frv_leak_pool_if.sv
`default_nettype none
// ============================================================================
//  Module   : frv_leak_pool_if
//  Purpose  : Bus bundle between the execute stage and the leakage pool.
//             slave  modport : the pool block
//             master modport : the execute-stage side
//  Signals  : leak_cfg_load/wdata, leak_lkgcfg      - lkgcfg register access
//             leak_seed_load/wdata                  - software reseed
//             leak_fence_valid/ready, leak_prng     - fence word handshake
//             leak_pool_level                       - valid pool entries
//             leak_stall_count (FRV_LEAK_POOL_STALL_CNT_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
interface frv_leak_pool_if #(
    parameter int XLEN  = 32,
    parameter int CFG_W = 13,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             leak_cfg_load;
    logic [XLEN-1:0]  leak_cfg_wdata;
    logic [CFG_W-1:0] leak_lkgcfg;
    logic             leak_seed_load;
    logic [XLEN-1:0]  leak_seed_wdata;
    logic             leak_fence_valid;
    logic             leak_fence_ready;
    logic [XLEN-1:0]  leak_prng;
    logic [LVL_W-1:0] leak_pool_level;
`ifdef FRV_LEAK_POOL_STALL_CNT_EN
    logic [15:0]      leak_stall_count;

    modport slave (
        input  leak_cfg_load, leak_cfg_wdata, leak_seed_load, leak_seed_wdata,
               leak_fence_valid,
        output leak_lkgcfg, leak_fence_ready, leak_prng, leak_pool_level,
               leak_stall_count
    );
    modport master (
        output leak_cfg_load, leak_cfg_wdata, leak_seed_load, leak_seed_wdata,
               leak_fence_valid,
        input  leak_lkgcfg, leak_fence_ready, leak_prng, leak_pool_level,
               leak_stall_count
    );
`else
    modport slave (
        input  leak_cfg_load, leak_cfg_wdata, leak_seed_load, leak_seed_wdata,
               leak_fence_valid,
        output leak_lkgcfg, leak_fence_ready, leak_prng, leak_pool_level
    );
    modport master (
        output leak_cfg_load, leak_cfg_wdata, leak_seed_load, leak_seed_wdata,
               leak_fence_valid,
        input  leak_lkgcfg, leak_fence_ready, leak_prng, leak_pool_level
    );
`endif
endinterface
`default_nettype wire

// File: rtl/frv_leak_pool_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : frv_leak_pool_fifo
//  Purpose  : DEPTH x XLEN word store for the random pool. Pointers wrap
//             modulo DEPTH (power of two); flush empties it in one cycle.
//  Ports    : g_clk, g_resetn (sync, active-low)
//             flush              - discard contents (wins over push/pop)
//             push, push_data    - append a word
//             pop, pop_data      - oldest word (combinational), consumed on pop
//             level              - number of valid entries
//  Revision : 1.0 - initial release
// ============================================================================
module frv_leak_pool_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                       g_clk,
    input  wire logic                       g_resetn,
    input  wire logic                       flush,
    input  wire logic                       push,
    input  wire logic [XLEN-1:0]            push_data,
    input  wire logic                       pop,
    output logic      [XLEN-1:0]            pop_data,
    output logic      [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    always_ff @(posedge g_clk) begin
        if (!g_resetn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (push && !pop)      r_level <= r_level + LVL_W'(1);
            else if (pop && !push) r_level <= r_level - LVL_W'(1);
        end
    end

    // Storage needs no reset: entries are only visible through the level.
    always_ff @(posedge g_clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/frv_leak_pool.sv
`default_nettype none
// ============================================================================
//  Module   : frv_leak_pool
//  Purpose  : lkgcfg register plus an XNOR Fibonacci LFSR that pre-fills a
//             DEPTH-entry pool of random words; leakage fences pop a word via
//             valid/ready. Software reseed XORs into the LFSR, flushes the
//             pool and guards against the all-ones lock-up state.
//  Ports    : g_clk, g_resetn (sync, active-low)
//             bus (frv_leak_pool_if.slave) - config, reseed, fence handshake
//  Options  : FRV_LEAK_POOL_STALL_CNT_EN - adds leak_stall_count, a saturating
//             count of cycles a fence waited on an empty/flushing pool.
//  Revision : 1.0 - initial release
// ============================================================================
module frv_leak_pool
    import frv_leak_pool_pkg::*;
#(
    parameter int               XLEN                 = 32,
    parameter int               CFG_W                = 13,
    parameter int               DEPTH                = 4,
    parameter logic [XLEN-1:0]  LFSR_TAPS            = XLEN'(LEAK_DEF_TAPS),
    parameter logic [XLEN-1:0]  PRNG_RESET_VALUE     = XLEN'(LEAK_DEF_RESET),
    parameter logic [CFG_W-1:0] CFG_RESET_VALUE      = '0,
    parameter bit               XC_CLASS_LEAK        = 1'b1,
    parameter bit               XC_CLASS_LEAK_STRONG = 1'b1
) (
    input  wire logic     g_clk,
    input  wire logic     g_resetn,
    frv_leak_pool_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [CFG_W-1:0] w_cfg;
    logic             w_ready;
    logic [XLEN-1:0]  w_prng;
    logic [LVL_W-1:0] w_level;

    if (XC_CLASS_LEAK) begin : g_leak
        logic [CFG_W-1:0] r_cfg;

        always_ff @(posedge g_clk) begin
            if (!g_resetn)              r_cfg <= CFG_RESET_VALUE;
            else if (bus.leak_cfg_load) r_cfg <= bus.leak_cfg_wdata[CFG_W-1:0];
        end
        assign w_cfg = r_cfg;

        if (CFG_W < XLEN) begin : g_cfg_pad
            logic w_unused_cfg_hi;
            assign w_unused_cfg_hi = ^bus.leak_cfg_wdata[XLEN-1:CFG_W];
        end

        if (XC_CLASS_LEAK_STRONG) begin : g_strong
            leak_state_t      r_state;
            logic [XLEN-1:0]  r_lfsr;
            logic [XLEN-1:0]  r_prng;
            logic [XLEN-1:0]  w_lfsr_next;
            logic [XLEN-1:0]  w_seeded;
            logic [XLEN-1:0]  w_pop_data;
            logic [LVL_W-1:0] w_fifo_level;
            logic             w_ready_s;
            logic             w_push;
            logic             w_pop;

            assign w_lfsr_next = XLEN'(lfsr_next(LEAK_MAX_W'(r_lfsr),
                                                 LEAK_MAX_W'(LFSR_TAPS)));
            assign w_seeded    = r_lfsr ^ bus.leak_seed_wdata;

            // A reseed blocks the fence in the same cycle so the popped word
            // can never predate the new seed.
            assign w_ready_s = (w_fifo_level != '0) && (r_state != ST_FLUSH)
                             && !bus.leak_seed_load;
            assign w_pop     = bus.leak_fence_valid && w_ready_s;
            assign w_push    = (r_state == ST_FILL) && !bus.leak_seed_load
                             && (w_fifo_level != LVL_W'(DEPTH));

            frv_leak_pool_fifo #(
                .XLEN  (XLEN),
                .DEPTH (DEPTH)
            ) u_fifo (
                .g_clk     (g_clk),
                .g_resetn  (g_resetn),
                .flush     (bus.leak_seed_load),
                .push      (w_push),
                .push_data (r_lfsr),
                .pop       (w_pop),
                .pop_data  (w_pop_data),
                .level     (w_fifo_level)
            );

            always_ff @(posedge g_clk) begin
                if (!g_resetn) begin
                    r_state <= ST_FILL;
                    r_lfsr  <= PRNG_RESET_VALUE;
                    r_prng  <= '0;
                end else if (bus.leak_seed_load) begin
                    // All-ones is the XNOR LFSR's stuck state.
                    r_lfsr  <= (&w_seeded) ? PRNG_RESET_VALUE : w_seeded;
                    r_state <= ST_FLUSH;
                end else begin
                    if (w_push) r_lfsr <= w_lfsr_next;
                    if (w_pop)  r_prng <= w_pop_data;
                    case (r_state)
                        ST_FILL: begin
                            if (w_push && !w_pop
                                && (w_fifo_level == LVL_W'(DEPTH - 1)))
                                r_state <= ST_FULL;
                        end
                        ST_FULL: begin
                            if (w_pop) r_state <= ST_FILL;
                        end
                        default: r_state <= ST_FILL;
                    endcase
                end
            end

            assign w_ready = w_ready_s;
            assign w_prng  = r_prng;
            assign w_level = w_fifo_level;
        end else begin : g_weak
            logic w_unused_weak;
            assign w_unused_weak = ^{bus.leak_seed_wdata, bus.leak_seed_load,
                                     bus.leak_fence_valid};
            assign w_ready = 1'b1;
            assign w_prng  = '0;
            assign w_level = '0;
        end
    end else begin : g_none
        logic w_unused_none;
        assign w_unused_none = ^{bus.leak_cfg_wdata, bus.leak_cfg_load,
                                 bus.leak_seed_wdata, bus.leak_seed_load,
                                 bus.leak_fence_valid};
        assign w_cfg   = '0;
        assign w_ready = 1'b1;
        assign w_prng  = '0;
        assign w_level = '0;
    end

`ifdef FRV_LEAK_POOL_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge g_clk) begin
        if (!g_resetn || bus.leak_seed_load)
            r_stall_count <= '0;
        else if (bus.leak_fence_valid && !w_ready && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'd1;
    end
    assign bus.leak_stall_count = r_stall_count;
`endif

    assign bus.leak_lkgcfg      = w_cfg;
    assign bus.leak_fence_ready = w_ready;
    assign bus.leak_prng        = w_prng;
    assign bus.leak_pool_level  = w_level;

endmodule
`default_nettype wire

// File: tb/tb_frv_leak_pool.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frv_leak_pool
//  Purpose  : Self-checking bench for frv_leak_pool. Each table row is one
//             clock cycle of stimulus with the ready/level expected in that
//             cycle; a reference pool model feeds a scoreboard of words the
//             fence should receive.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frv_leak_pool;
    localparam int          XLEN  = 32;
    localparam int          CFG_W = 13;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TAPS  = 32'h80200003;
    localparam logic [31:0] RSTV  = 32'hABCDEF37;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    frv_leak_pool_if #(.XLEN(XLEN), .CFG_W(CFG_W), .DEPTH(DEPTH)) bus();

    frv_leak_pool #(.XLEN(XLEN), .CFG_W(CFG_W), .DEPTH(DEPTH)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          seed;
        bit          lock;   // seed word = ~model lfsr (forces all-ones)
        logic [31:0] swd;
        bit          v;
        bit          cl;
        logic [31:0] cwd;
        bit          rdy;
        int          lvl;
        bit          pchk;   // check leak_prng against pexp after the edge
        logic [31:0] pexp;
    } row_t;

    row_t rows[$];

    // Reference model state.
    logic [31:0] m_lfsr;
    logic [31:0] m_prng;
    logic [31:0] m_pool[$];
    logic [31:0] sb[$];
    bit          m_flush;
    logic [12:0] m_cfg;
    logic [15:0] m_cnt;

    function automatic row_t mk(bit seed, bit lock, logic [31:0] swd, bit v,
                                bit cl, logic [31:0] cwd, bit rdy, int lvl,
                                bit pchk, logic [31:0] pexp);
        row_t r;
        r.seed = seed; r.lock = lock; r.swd = swd; r.v = v; r.cl = cl;
        r.cwd = cwd; r.rdy = rdy; r.lvl = lvl; r.pchk = pchk; r.pexp = pexp;
        return r;
    endfunction

    function automatic logic [31:0] m_step(logic [31:0] s);
        logic fb;
        fb = 1'b1;
        for (int i = 0; i < 32; i++)
            if (TAPS[i]) fb = fb ^ s[i];
        return {s[30:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = RSTV;
        m_prng  = '0;
        m_pool.delete();
        sb.delete();
        m_flush = 1'b0;
        m_cfg   = '0;
        m_cnt   = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model,
    // clock, then compare registered outputs.
    task automatic run_row(input row_t r);
        logic [31:0] swd;
        logic [31:0] x;
        bit          rdy_m, xfer, push_m;
        swd = r.lock ? ~m_lfsr : r.swd;
        bus.leak_seed_load   = r.seed;
        bus.leak_seed_wdata  = swd;
        bus.leak_fence_valid = r.v;
        bus.leak_cfg_load    = r.cl;
        bus.leak_cfg_wdata   = r.cwd;
        #1;
        chk("ready", 32'(bus.leak_fence_ready), 32'(r.rdy));
        chk("level", 32'(bus.leak_pool_level), 32'(r.lvl));

        rdy_m  = (m_pool.size() != 0) && !m_flush && !r.seed;
        xfer   = r.v && rdy_m;
        push_m = !m_flush && !r.seed && (m_pool.size() < DEPTH);
        if (r.seed)                         m_cnt = '0;
        else if (r.v && !rdy_m && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (r.seed) begin
            x       = m_lfsr ^ swd;
            m_lfsr  = (&x) ? RSTV : x;
            m_pool.delete();
            m_flush = 1'b1;
        end else begin
            if (xfer) begin
                m_prng = m_pool.pop_front();
                sb.push_back(m_prng);
            end
            if (push_m) begin
                m_pool.push_back(m_lfsr);
                m_lfsr = m_step(m_lfsr);
            end
            m_flush = 1'b0;
        end
        if (r.cl) m_cfg = r.cwd[12:0];

        @(posedge g_clk);
        #1;
        if (sb.size() != 0) chk("prng_pop", bus.leak_prng, sb.pop_front());
        else                chk("prng_hold", bus.leak_prng, m_prng);
        chk("cfg", 32'(bus.leak_lkgcfg), 32'(m_cfg));
        if (r.pchk) chk("prng_const", bus.leak_prng, r.pexp);
`ifdef FRV_LEAK_POOL_STALL_CNT_EN
        chk("stall", 32'(bus.leak_stall_count), 32'(m_cnt));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_level"}, 32'(bus.leak_pool_level), 32'd0);
        chk({tag, "_ready"}, 32'(bus.leak_fence_ready), 32'd0);
        chk({tag, "_prng"},  bus.leak_prng, 32'd0);
        chk({tag, "_cfg"},   32'(bus.leak_lkgcfg), 32'd0);
`ifdef FRV_LEAK_POOL_STALL_CNT_EN
        chk({tag, "_stall"}, 32'(bus.leak_stall_count), 32'd0);
`endif
    endtask

    initial begin
        //            seed lk swd           v  cl cwd           rdy lvl pchk pexp
        // reset fill
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 0, 32'h0));
        // first two pops
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 4, 1, 32'hABCDEF37));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 3, 1, 32'h579BDE6E));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 0, 32'h0));
        // reseed 0 with simultaneous fence and cfg load, then refill
        rows.push_back(mk(1, 0, 32'h0,        1, 1, 32'h12345678, 0, 4, 1, 32'h579BDE6E));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 0, 32'h0));
        // lock-up guard
        rows.push_back(mk(1, 1, 32'h0,        0, 0, 32'h0,        0, 4, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_1FFF, 1, 1, 1, 32'hABCDEF37));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0));
        // reseed during flush restarts flush
        rows.push_back(mk(1, 0, 32'h1,        0, 0, 32'h0,        0, 2, 0, 32'h0));
        rows.push_back(mk(1, 0, 32'h80000000, 0, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h0));
        rows.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0));

        bus.leak_cfg_load    = 1'b0;
        bus.leak_cfg_wdata   = '0;
        bus.leak_seed_load   = 1'b0;
        bus.leak_seed_wdata  = '0;
        bus.leak_fence_valid = 1'b0;
        g_resetn             = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        check_reset_state("rst");
        model_reset();
        g_resetn = 1'b1;

        for (int i = 0; i < rows.size(); i++) run_row(rows[i]);

        // Reset in the middle of operation, with requests active.
        g_resetn             = 1'b0;
        bus.leak_fence_valid = 1'b1;
        bus.leak_cfg_load    = 1'b1;
        bus.leak_cfg_wdata   = 32'h0000_0ABC;
        @(posedge g_clk);
        #1;
        check_reset_state("midrst");
        model_reset();
        g_resetn = 1'b1;

        // Fence held high from reset release: one stall, then a word per cycle.
        run_row(mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 32'h0));
        run_row(mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 1, 32'hABCDEF37));
        run_row(mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 1, 32'h579BDE6E));
        run_row(mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 32'h0));
        run_row(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 32'h0));
`ifdef FRV_LEAK_POOL_STALL_CNT_EN
        chk("stall_const", 32'(bus.leak_stall_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frv_leak_pool.md
Name: frv_leak_pool

Overview:
- Successor to the core's leakage-barrier state block.
- Holds the lkgcfg configuration register and a parametrised Galois-free (Fibonacci, XNOR) LFSR.
- Buffers pre-generated random words in a DEPTH-entry pool, so a leakage fence pops a fresh word through a valid/ready handshake instead of stepping the LFSR in-line.
- Adds software reseeding with pool flush and lock-up protection; sits beside the execute stage and feeds the register-randomisation logic.

Parameters:
XLEN, 32, data/LFSR width in bits
CFG_W, 13, lkgcfg register width (CFG_W <= XLEN)
DEPTH, 4, pool entries (power of two, >= 2)
LFSR_TAPS, 32'h80200003, tap mask; feedback bit = XNOR-reduction of (lfsr & LFSR_TAPS)
PRNG_RESET_VALUE, 32'hABCDEF37, LFSR reset/recovery value (must not be all-ones)
CFG_RESET_VALUE, 0, lkgcfg reset value
XC_CLASS_LEAK, 1, block implemented
XC_CLASS_LEAK_STRONG, 1, PRNG/pool implemented

Ports:
g_clk  in  1  clock
g_resetn  in  1  reset; synchronous, active-low, sampled on g_clk rising edge
leak_cfg_load  in  1  load lkgcfg
leak_cfg_wdata  in  XLEN  new config; low CFG_W bits used
leak_lkgcfg  out  CFG_W  current config
leak_seed_load  in  1  reseed request
leak_seed_wdata  in  XLEN  seed word, XORed into LFSR
leak_fence_valid  in  1  fence instruction requests a word
leak_fence_ready  out  1  pool can supply a word this cycle
leak_prng  out  XLEN  last word handed to a fence (registered)
leak_pool_level  out  $clog2(DEPTH+1)  valid pool entries

Behaviour:
- Reset values:
  - leak_lkgcfg = CFG_RESET_VALUE
  - leak_prng = 0
  - LFSR = PRNG_RESET_VALUE
  - pool empty, level 0
  - FSM = FILL
- Config: leak_cfg_load registers leak_cfg_wdata[CFG_W-1:0] next cycle. Independent of the pool.
- LFSR step: lfsr <= {lfsr[XLEN-2:0], fb}.
- FSM states:
  - FILL: pool not full. Each cycle push the current lfsr, then step it. Go to FULL when the push makes level == DEPTH and no pop occurs.
  - FULL: no push, LFSR holds. Return to FILL on any pop.
  - FLUSH: one cycle, entered on reseed. No push, no pop, ready = 0. Next state is FILL.
- Fence handshake:
  - leak_fence_ready = (level != 0) && state != FLUSH && !leak_seed_load.
  - Transfer occurs when valid && ready: pop the oldest entry into leak_prng at the next edge.
  - leak_prng holds its value otherwise.
- Push and pop in the same cycle are allowed. Level is unchanged, and the word popped is the oldest entry, never the word being pushed.
- Empty pool (level 0): ready = 0, so a fence stalls. A push into an empty pool is poppable the following cycle (1-cycle fill latency).
- Reseed, when leak_seed_load = 1:
  - lfsr <= lfsr ^ leak_seed_wdata; if the result is all-ones (XNOR lock-up), load PRNG_RESET_VALUE instead.
  - The pool is flushed (level 0) and the FSM enters FLUSH.
  - Reseed beats fence and push in the same cycle.
  - Reseed during FLUSH restarts FLUSH.
- Read/write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- A reset mid-operation discards the pool and all state.
- XC_CLASS_LEAK_STRONG = 0: no LFSR or pool; leak_prng = 0, ready = 1, level = 0.
- XC_CLASS_LEAK = 0: all outputs constant 0 except ready = 1.

Optional Feature:
- Macro: FRV_LEAK_POOL_STALL_CNT_EN.
- Defined: adds output leak_stall_count [15:0].
  - Resets to 0.
  - Increments each cycle leak_fence_valid && !leak_fence_ready.
  - Saturates at 16'hFFFF.
  - Cleared on leak_seed_load.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (FILL/FULL/FLUSH), default LFSR_TAPS and PRNG_RESET_VALUE constants, function lfsr_next(state, taps).
- One sub-module, frv_leak_pool_fifo: DEPTH x XLEN storage, pointers, level, flush input.

Test Plan:
- Reset fill: release reset, fence_valid = 0 → level goes 1, 2, 3, 4 on successive cycles, then holds at 4 in FULL.
- First pops: two back-to-back fences after the pool is full → leak_prng = 32'hABCDEF37, then 32'h579BDE6E; ready stays 1 because refill overlaps the pops.
- Empty stall: DEPTH=4, fence_valid held high from the cycle reset releases → ready = 0 on the first cycle, then 1; one transfer per cycle thereafter; stall count (if enabled) = 1.
- Reseed: pool full, then seed_load with wdata 0 → ready = 0 for 2 cycles, level 0, then refill restarts from the unchanged lfsr value.
- Lock-up guard: seed_wdata = lfsr ^ 32'hFFFFFFFF → lfsr = 32'hABCDEF37, and the next popped word = 32'hABCDEF37.
- Simultaneous events: seed_load and fence_valid in the same cycle → no transfer, leak_prng unchanged; cfg_load in the same cycle → leak_lkgcfg = wdata[12:0] next cycle.
